// File: rtl/memory_programmer_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : memory_programmer_stream                                     |
// | Description : Parametrised RAM loader. Accepts a valid/ready word stream    |
// |               and writes WORD_COUNT words into a single-port synchronous    |
// |               RAM starting at BASE_ADDR, with start/abort/done control.     |
// |               Optional build macro MEM_PROG_VERIFY_EN adds a readback pass  |
// |               that sums the RAM contents and flags a checksum mismatch.     |
// | Ports       : clock_in/reset     - system clock, async active-high reset    |
// |               start/abort        - run control                              |
// |               data_in/data_valid/data_ready - input word stream             |
// |               q_in               - RAM read data (verify pass only)         |
// |               clock_out/wr_en_out/address_out/data_out - RAM interface      |
// |               busy/done/error    - status                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module memory_programmer_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0,
   parameter int WORD_COUNT = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clock_in,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [DATA_WIDTH-1:0] q_in,
   output logic                  clock_out,
   output logic                  wr_en_out,
   output logic [ADDR_WIDTH-1:0] address_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   // Counter must hold WORD_COUNT itself (verify issue counter runs up to it)
   localparam int                   c_cnt_w    = $clog2(WORD_COUNT + 1);
   localparam logic [ADDR_WIDTH-1:0] c_base    = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [c_cnt_w-1:0]   c_last_cnt = c_cnt_w'(WORD_COUNT - 1);
   localparam logic [c_cnt_w-1:0]   c_one      = c_cnt_w'(1);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_write  = 2'd1;
   localparam logic [1:0] c_st_verify = 2'd2;
   localparam logic [1:0] c_st_done   = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [c_cnt_w-1:0]    r_count;
   logic [15:0]           r_checksum;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_busy;
   logic                  r_done;

   logic w_run_start;
   logic w_beat;
   logic w_last_beat;
   logic w_wr_en_nxt;
   logic w_busy_nxt;
   logic w_done_nxt;
   logic w_verify_done;

   assign clock_out   = clock_in;
   assign data_ready  = (r_state == c_st_write);
   assign wr_en_out   = r_wr_en;
   assign address_out = r_addr;
   assign data_out    = r_data;
   assign busy        = r_busy;
   assign done        = r_done;

   assign w_run_start = (r_state == c_st_idle) && start;
   assign w_beat      = data_valid && data_ready;
   assign w_last_beat = w_beat && (r_count == c_last_cnt);

`ifdef MEM_PROG_VERIFY_EN
   logic [c_cnt_w-1:0]  r_vaddr_cnt;    // readback addresses issued
   logic [c_cnt_w-1:0]  r_vsample_cnt;  // readback words summed
   logic [15:0]         r_rsum;
   // Bit 0 marks an address issued this edge; bit RD_LATENCY lines up with the
   // edge at which the RAM data for that address is on q_in (RAM registers the
   // address one edge after it is driven, then RD_LATENCY-1 further stages).
   logic [RD_LATENCY:0] r_vpipe;
   logic                r_error;
   logic                w_vissue;
   logic                w_verify_step;
   logic                w_enter_verify;
   logic [15:0]         w_rsum_final;

   assign w_vissue       = (r_vaddr_cnt != c_cnt_w'(WORD_COUNT));
   assign w_verify_step  = (r_state == c_st_verify) && !abort;
   assign w_enter_verify = w_last_beat && !abort;
   assign w_rsum_final   = r_rsum + 16'(q_in);
   assign w_verify_done  = (r_state == c_st_verify) && r_vpipe[RD_LATENCY] &&
                           (r_vsample_cnt == c_last_cnt);
   assign error          = r_error;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_vaddr_cnt   <= '0;
         r_vsample_cnt <= '0;
         r_rsum        <= '0;
         r_vpipe       <= '0;
         r_error       <= 1'b0;
      end else if (w_run_start) begin
         r_error <= 1'b0;
      end else if (w_enter_verify) begin
         r_vaddr_cnt   <= '0;
         r_vsample_cnt <= '0;
         r_rsum        <= '0;
         r_vpipe       <= '0;
      end else if (w_verify_step) begin
         if (w_vissue) begin
            r_vaddr_cnt <= r_vaddr_cnt + c_one;
         end
         r_vpipe <= {r_vpipe[RD_LATENCY-1:0], w_vissue};
         if (r_vpipe[RD_LATENCY]) begin
            r_rsum        <= w_rsum_final;
            r_vsample_cnt <= r_vsample_cnt + c_one;
         end
         if (w_verify_done) begin
            r_error <= (w_rsum_final != r_checksum);
         end
      end
   end
`else
   // Readback path not built; keep q_in and RD_LATENCY referenced
   logic w_unused_cfg;
   assign w_unused_cfg  = (^q_in) ^ (RD_LATENCY > 4);
   assign w_verify_done = 1'b0;
   assign error         = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   // abort outranks everything else, including a beat arriving on that edge
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) begin
               w_state_nxt = c_st_write;
            end
         end
         c_st_write: begin
            if (abort) begin
               w_state_nxt = c_st_idle;
            end else if (w_last_beat) begin
`ifdef MEM_PROG_VERIFY_EN
               w_state_nxt = c_st_verify;
`else
               w_state_nxt = c_st_done;
`endif
            end
         end
         c_st_verify: begin
            if (abort) begin
               w_state_nxt = c_st_idle;
            end else if (w_verify_done) begin
               w_state_nxt = c_st_done;
            end
         end
         c_st_done: begin
            w_state_nxt = c_st_idle;
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // ------------------------------------------------------------ output decode
   // Registered status follows the state being entered, so busy/done line up
   // with the state they describe rather than trailing it by a cycle.
   always_comb begin
      w_wr_en_nxt = w_beat && !abort;
      w_busy_nxt  = (w_state_nxt != c_st_idle);
      w_done_nxt  = (w_state_nxt == c_st_done);
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_wr_en    <= 1'b0;
         r_addr     <= c_base;
         r_data     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= '0;
         r_checksum <= '0;
      end else begin
         r_wr_en <= w_wr_en_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_run_start) begin
            r_count    <= '0;
            r_checksum <= '0;
            r_addr     <= c_base;
         end else if (w_wr_en_nxt) begin
            // Address truncates to ADDR_WIDTH, so runs wrap past the top of RAM
            r_addr     <= c_base + ADDR_WIDTH'(r_count);
            r_data     <= data_in;
            r_count    <= r_count + c_one;
            r_checksum <= r_checksum + 16'(data_in);
         end
`ifdef MEM_PROG_VERIFY_EN
         else if (w_verify_step && w_vissue) begin
            r_addr <= c_base + ADDR_WIDTH'(r_vaddr_cnt);
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_programmer_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_memory_programmer_stream                                  |
// | Description : Directed self-checking bench. Two loaders (BASE 0x10 and     |
// |               BASE 0xFE, four words each) share the stream inputs; each     |
// |               drives its own behavioural synchronous RAM model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_memory_programmer_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, sel, abort, dvalid;
   logic [7:0] din;
   logic       start_a, start_b;

   logic       rdy_a, ck_a, wr_a, busy_a, done_a, err_a;
   logic [7:0] addr_a, dout_a, q_a;
   logic       rdy_b, ck_b, wr_b, busy_b, done_b, err_b;
   logic [7:0] addr_b, dout_b, q_b;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   int         nwr_a, nwr_b, ndone_a;
   logic       clr, corrupt_a;

   logic [7:0] words [4];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   memory_programmer_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BASE_ADDR(8'h10),
                              .WORD_COUNT(4), .RD_LATENCY(1)) dut_a (
      .clock_in(clk), .reset(rst), .start(start_a), .abort(abort),
      .data_in(din), .data_valid(dvalid), .data_ready(rdy_a), .q_in(q_a),
      .clock_out(ck_a), .wr_en_out(wr_a), .address_out(addr_a), .data_out(dout_a),
      .busy(busy_a), .done(done_a), .error(err_a));

   memory_programmer_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BASE_ADDR(8'hFE),
                              .WORD_COUNT(4), .RD_LATENCY(1)) dut_b (
      .clock_in(clk), .reset(rst), .start(start_b), .abort(abort),
      .data_in(din), .data_valid(dvalid), .data_ready(rdy_b), .q_in(q_b),
      .clock_out(ck_b), .wr_en_out(wr_b), .address_out(addr_b), .data_out(dout_b),
      .busy(busy_b), .done(done_b), .error(err_b));

   // RAM models: write on wr_en, read-first registered q (latency 1).
   // corrupt_a flips bit 0 of whatever lands at 0x11 in RAM A.
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 8'h00;
            mem_b[i] <= 8'h00;
         end
         nwr_a   <= 0;
         nwr_b   <= 0;
         ndone_a <= 0;
      end else begin
         if (wr_a) begin
            mem_a[addr_a] <= (corrupt_a && addr_a == 8'h11) ? (dout_a ^ 8'h01) : dout_a;
            nwr_a <= nwr_a + 1;
         end
         if (wr_b) begin
            mem_b[addr_b] <= dout_b;
            nwr_b <= nwr_b + 1;
         end
         if (done_a) ndone_a <= ndone_a + 1;
      end
      q_a <= mem_a[addr_a];
      q_b <= mem_b[addr_b];
   end

   logic       m_rdy, m_wr, m_busy, m_done, m_err;
   logic [7:0] m_addr, m_dout;
   assign m_rdy  = sel ? rdy_b  : rdy_a;
   assign m_wr   = sel ? wr_b   : wr_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_done = sel ? done_b : done_a;
   assign m_err  = sel ? err_b  : err_a;
   assign m_addr = sel ? addr_b : addr_a;
   assign m_dout = sel ? dout_b : dout_a;

   function automatic logic [7:0] mem_rd(input logic s, input logic [7:0] a);
      return s ? mem_b[a] : mem_a[a];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_clr();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
   endtask

   // One full run of words[] on loader s, with gap idle cycles before each beat.
   // start is held high during gaps to show it is ignored while busy.
   task automatic run(input logic s, input logic [7:0] base, input int gap, input logic exp_err);
      int         wr0;
      int         n;
      logic [7:0] ea;
      sel = s;
      wr0 = s ? nwr_b : nwr_a;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check_eq("start_busy", m_busy, 1);
      check_eq("start_ready", m_rdy, 1);
      check_eq("start_err_clr", m_err, 0);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            dvalid = 1'b0; din = 8'h5A; start = 1'b1;
            @(negedge clk);
            check_eq("gap_wr", m_wr, 0);
         end
         start = 1'b0; dvalid = 1'b1; din = words[i];
         @(negedge clk);
         ea = base + 8'(i);
         check_eq("beat_wr", m_wr, 1);
         check_eq("beat_addr", m_addr, ea);
         check_eq("beat_data", m_dout, words[i]);
      end
      dvalid = 1'b0;
      check_eq("last_ready", m_rdy, 0);
`ifndef MEM_PROG_VERIFY_EN
      check_eq("done_latency", m_done, 1);
`endif
      n = 0;
      while (!m_done && n < 64) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_seen", m_done, 1);
      check_eq("done_busy", m_busy, 1);
      check_eq("done_err", m_err, exp_err);
      @(negedge clk);
      check_eq("done_one_cycle", m_done, 0);
      check_eq("idle_busy", m_busy, 0);
      for (int i = 0; i < 4; i++) begin
         ea = base + 8'(i);
         check_eq("ram_image", mem_rd(s, ea),
                  words[i] ^ ((exp_err && ea == 8'h11) ? 8'h01 : 8'h00));
      end
      check_eq("write_count", (s ? nwr_b : nwr_a) - wr0, 4);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sel = 1'b0; abort = 1'b0;
      dvalid = 1'b0; din = 8'h00; clr = 1'b1; corrupt_a = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_ready", rdy_a, 0);
      check_eq("rst_wr", wr_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_err", err_a, 0);
      check_eq("rst_addr_a", addr_a, 8'h10);
      check_eq("rst_addr_b", addr_b, 8'hFE);
      check_eq("rst_data", dout_a, 0);
      check_eq("clock_out", ck_a, clk);
      clr = 1'b0; rst = 1'b0;
      @(negedge clk);

      // back-to-back stream
      words[0] = 8'h11; words[1] = 8'hAA; words[2] = 8'hFF; words[3] = 8'h55;
      run(1'b0, 8'h10, 0, 1'b0);

      // gapped stream, two idle cycles per beat
      do_clr();
      run(1'b0, 8'h10, 2, 1'b0);

      // address wrap on the second loader
      do_clr();
      words[0] = 8'hC1; words[1] = 8'hC2; words[2] = 8'hC3; words[3] = 8'hC4;
      run(1'b1, 8'hFE, 0, 1'b0);
      check_eq("wrap_no_extra", mem_b[8'h02], 8'h00);

      // abort on the third beat
      do_clr();
      words[0] = 8'h11; words[1] = 8'hAA; words[2] = 8'hFF; words[3] = 8'h55;
      sel = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         dvalid = 1'b1; din = words[i];
         @(negedge clk);
      end
      dvalid = 1'b1; din = words[2]; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; dvalid = 1'b0;
      check_eq("abort_wr", wr_a, 0);
      check_eq("abort_ready", rdy_a, 0);
      check_eq("abort_busy", busy_a, 0);
      check_eq("abort_done", done_a, 0);
      repeat (3) @(negedge clk);
      check_eq("abort_no_done", ndone_a, 0);
      check_eq("abort_writes", nwr_a, 2);
      check_eq("abort_beat_dropped", mem_a[8'h12], 8'h00);
      check_eq("abort_kept", mem_a[8'h11], 8'hAA);
      run(1'b0, 8'h10, 0, 1'b0);

      // reset asserted mid-clock with a write in flight
      do_clr();
      sel = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      dvalid = 1'b1; din = 8'hC3;
      @(negedge clk);
      din = 8'h3C;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_wr", wr_a, 0);
      check_eq("mid_rst_addr", addr_a, 8'h10);
      check_eq("mid_rst_data", dout_a, 0);
      check_eq("mid_rst_busy", busy_a, 0);
      check_eq("mid_rst_ready", rdy_a, 0);
      check_eq("mid_rst_done", done_a, 0);
      dvalid = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_writes", nwr_a, 1);
      check_eq("mid_rst_first", mem_a[8'h10], 8'hC3);
      check_eq("mid_rst_dropped", mem_a[8'h11], 8'h00);
      run(1'b0, 8'h10, 0, 1'b0);

`ifdef MEM_PROG_VERIFY_EN
      // readback with a corrupted word, then a clean rerun clears error
      do_clr();
      corrupt_a = 1'b1;
      run(1'b0, 8'h10, 0, 1'b1);
      corrupt_a = 1'b0;
      run(1'b0, 8'h10, 0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
